// File: rtl/mem_controller_pkg.sv
// Shared types and helpers for the memory-side request multiplexer.
package mem_controller_pkg;

  // Life cycle of one external memory channel.
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } channel_state_t;

  // Width of a lane index; a single lane still needs one bit to index it.
  function automatic int lane_bits(input int num_consumers);
    return (num_consumers > 1) ? $clog2(num_consumers) : 1;
  endfunction

endpackage

// File: rtl/mem_channel.sv
// One memory channel: owns a claimed lane from claim until the lane
// releases its valid, issuing the memory request and holding the response.
module mem_channel
  import mem_controller_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LANE_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 claim,
  input  logic                 claim_read,
  input  logic [LANE_BITS-1:0] claim_lane,
  input  logic [ADDR_BITS-1:0] claim_address,
  input  logic [DATA_BITS-1:0] claim_data,
  input  logic                 lane_read_valid,
  input  logic                 lane_write_valid,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  input  logic                 mem_write_ready,
  output channel_state_t       state,
  output logic [LANE_BITS-1:0] lane,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data
);

  channel_state_t       state_reg, state_next;
  logic [LANE_BITS-1:0] lane_reg;
  logic [ADDR_BITS-1:0] address_reg;
  logic [DATA_BITS-1:0] wdata_reg;
  logic [DATA_BITS-1:0] rdata_reg;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: a relay only ends once the lane drops its valid.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:           if (claim) state_next = claim_read ? READ_WAITING : WRITE_WAITING;
      READ_WAITING:   if (mem_read_ready) state_next = READ_RELAYING;
      WRITE_WAITING:  if (mem_write_ready) state_next = WRITE_RELAYING;
      READ_RELAYING:  if (!lane_read_valid) state_next = IDLE;
      WRITE_RELAYING: if (!lane_write_valid) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  // Capture lane/address/data at claim and the memory read data on response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_reg    <= '0;
      address_reg <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
    end else begin
      if (state_reg == IDLE && claim) begin
        lane_reg    <= claim_lane;
        address_reg <= claim_address;
        wdata_reg   <= claim_data;
      end
      if (state_reg == READ_WAITING && mem_read_ready)
        rdata_reg <= mem_read_data;
      else if (state_reg == READ_RELAYING && !lane_read_valid)
        rdata_reg <= '0;
    end
  end

  // Memory-side outputs are purely a function of the registered state.
  always_comb begin
    mem_read_valid    = 1'b0;
    mem_read_address  = '0;
    mem_write_valid   = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    case (state_reg)
      READ_WAITING: begin
        mem_read_valid   = 1'b1;
        mem_read_address = address_reg;
      end
      WRITE_WAITING: begin
        mem_write_valid   = 1'b1;
        mem_write_address = address_reg;
        mem_write_data    = wdata_reg;
      end
      default: ;
    endcase
  end

  assign state     = state_reg;
  assign lane      = lane_reg;
  assign read_data = rdata_reg;

endmodule

// File: rtl/mem_controller.sv
// Multiplexes the dcache controller request lanes onto a smaller set of
// memory channels with a rotating claim pointer so no lane starves.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           controller_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] controller_read_address,
  output logic [NUM_CONSUMERS-1:0]           controller_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] controller_read_data,
  input  logic [NUM_CONSUMERS-1:0]           controller_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] controller_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] controller_write_data,
  output logic [NUM_CONSUMERS-1:0]           controller_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int LANE_BITS = lane_bits(NUM_CONSUMERS);

  logic                     write_path;
  logic [NUM_CONSUMERS-1:0] pending;
  logic [NUM_CONSUMERS-1:0] claimed_mask;
  logic [NUM_CHANNELS-1:0]  grant;
  logic [NUM_CHANNELS-1:0]  grant_read;
  logic [LANE_BITS-1:0]     grant_lane [NUM_CHANNELS];
  logic [LANE_BITS-1:0]     rr_ptr_reg, rr_ptr_next;

  channel_state_t           ch_state [NUM_CHANNELS];
  logic [LANE_BITS-1:0]     ch_lane  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     ch_rdata [NUM_CHANNELS];

  assign write_path = (WRITE_ENABLE != 0);
  assign pending    = controller_read_valid | (controller_write_valid & {NUM_CONSUMERS{write_path}});

  // A lane stays claimed for as long as any channel is busy with it,
  // including the relay cycle in which it is being released.
  always_comb begin
    claimed_mask = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (ch_state[c] != IDLE) claimed_mask[ch_lane[c]] = 1'b1;
  end

  // Claim scan: each idle channel in order takes the first pending,
  // unclaimed lane at or after rr_ptr; reads win over writes on a lane.
  always_comb begin : claim_scan
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    int                       idx;
    logic [LANE_BITS-1:0]     lane_idx;
    taken       = claimed_mask;
    found       = 1'b0;
    idx         = 0;
    lane_idx    = '0;
    grant       = '0;
    grant_read  = '0;
    rr_ptr_next = rr_ptr_reg;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      grant_lane[c] = '0;
      found         = 1'b0;
      if (ch_state[c] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          idx      = (int'(rr_ptr_reg) + k) % NUM_CONSUMERS;
          lane_idx = LANE_BITS'(idx);
          if (!found && pending[lane_idx] && !taken[lane_idx]) begin
            found           = 1'b1;
            grant[c]        = 1'b1;
            grant_lane[c]   = lane_idx;
            grant_read[c]   = controller_read_valid[lane_idx];
            taken[lane_idx] = 1'b1;
            rr_ptr_next     = LANE_BITS'((idx + 1) % NUM_CONSUMERS);
          end
        end
      end
    end
  end

  // Round-robin pointer follows the most recent grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr_reg <= '0;
    else        rr_ptr_reg <= rr_ptr_next;
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_channel
    logic [ADDR_BITS-1:0] claim_address;
    logic [DATA_BITS-1:0] claim_data;
    logic                 ch_write_valid;

    assign claim_address = grant_read[gi]
      ? controller_read_address[grant_lane[gi]*ADDR_BITS +: ADDR_BITS]
      : controller_write_address[grant_lane[gi]*ADDR_BITS +: ADDR_BITS];
    assign claim_data    = controller_write_data[grant_lane[gi]*DATA_BITS +: DATA_BITS];

    mem_channel #(
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS),
      .LANE_BITS(LANE_BITS)
    ) u_channel (
      .clk               (clk),
      .reset             (reset),
      .claim             (grant[gi]),
      .claim_read        (grant_read[gi]),
      .claim_lane        (grant_lane[gi]),
      .claim_address     (claim_address),
      .claim_data        (claim_data),
      .lane_read_valid   (controller_read_valid[ch_lane[gi]]),
      .lane_write_valid  (controller_write_valid[ch_lane[gi]]),
      .mem_read_ready    (mem_read_ready[gi]),
      .mem_read_data     (mem_read_data[gi*DATA_BITS +: DATA_BITS]),
      .mem_write_ready   (mem_write_ready[gi] & write_path),
      .state             (ch_state[gi]),
      .lane              (ch_lane[gi]),
      .read_data         (ch_rdata[gi]),
      .mem_read_valid    (mem_read_valid[gi]),
      .mem_read_address  (mem_read_address[gi*ADDR_BITS +: ADDR_BITS]),
      .mem_write_valid   (ch_write_valid),
      .mem_write_address (mem_write_address[gi*ADDR_BITS +: ADDR_BITS]),
      .mem_write_data    (mem_write_data[gi*DATA_BITS +: DATA_BITS])
    );

    assign mem_write_valid[gi] = ch_write_valid & write_path;
  end

  // Lane-side responses: each relaying channel drives its lane's ready/data.
  always_comb begin
    controller_read_ready  = '0;
    controller_read_data   = '0;
    controller_write_ready = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_state[c] == READ_RELAYING) begin
        controller_read_ready[ch_lane[c]] = 1'b1;
        controller_read_data[ch_lane[c]*DATA_BITS +: DATA_BITS] = ch_rdata[c];
      end
      if (write_path && ch_state[c] == WRITE_RELAYING)
        controller_write_ready[ch_lane[c]] = 1'b1;
    end
  end

endmodule
